counter_arb: RTL and testbench

COUNTER_ARB -- requirements
Module: counter_arb

---
 rtl/counter_arb.sv | 140 ++++++++++++++
 tb/tb_counter_arb.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/counter_arb.sv
// Round-robin arbiter that lets NUM_REQ requesters share one external counter,
// with a clear handshake; overflow halting is built only under COUNTER_ARB_HALT_ON_OVF_EN.
module counter_arb #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned CNT_INPUT_SIZE = 2,
   parameter int unsigned CNT_SIZE       = 16
) (
   input  logic                               clk,
   input  logic                               reset_L,
   input  logic [NUM_REQ-1:0]                 req_valid,
   input  logic [NUM_REQ*CNT_INPUT_SIZE-1:0]  req_inc,
   output logic [NUM_REQ-1:0]                 req_ready,
   input  logic                               clr_req,
   output logic                               clr_ack,
   output logic                               cnt_en,
   output logic [CNT_INPUT_SIZE-1:0]          cnt_inc,
   output logic                               cnt_clear,
   input  logic                               cnt_error_overflow,
   output logic                               ovf_halt
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef COUNTER_ARB_HALT_ON_OVF_EN
   typedef enum logic [1:0] {RUN = 2'd0, CLR = 2'd1, HALT = 2'd2} state_e;
`else
   typedef enum logic [0:0] {RUN = 1'b0, CLR = 1'b1} state_e;
`endif

   state_e                    state_q, state_d;
   logic [PTR_W-1:0]          last_grant_q, last_grant_d;
   logic [PTR_W-1:0]          gnt_idx;
   logic                      gnt_found;
   logic                      transfer;
   int unsigned               cand;
   logic [CNT_INPUT_SIZE-1:0] inc_arr [NUM_REQ];

   // The counter itself lives outside; its width only matters to the integrator.
   logic [CNT_SIZE-1:0]       unused_cnt_size;
   assign unused_cnt_size = '0;

`ifndef COUNTER_ARB_HALT_ON_OVF_EN
   logic                      unused_ovf;
   assign unused_ovf = cnt_error_overflow;
`endif

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
      assign inc_arr[i] = req_inc[i*CNT_INPUT_SIZE +: CNT_INPUT_SIZE];
   end

   // First valid requester searching upward from the slot after the last grant.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = (32'(last_grant_q) + k) % NUM_REQ;
         if (!gnt_found && req_valid[PTR_W'(cand)]) begin
            gnt_found = 1'b1;
            gnt_idx   = PTR_W'(cand);
         end
      end
   end

   // Clear outranks every requester; nothing is granted outside RUN.
   assign transfer = reset_L && (state_q == RUN) && !clr_req && gnt_found;

   always_comb begin
      last_grant_d = last_grant_q;
      if (transfer) begin
         last_grant_d = gnt_idx;
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q      <= RUN;
         last_grant_q <= PTR_W'(NUM_REQ - 1);
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Next state; a clear request beats an overflow seen in the same cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (clr_req) begin
               state_d = CLR;
            end
`ifdef COUNTER_ARB_HALT_ON_OVF_EN
            else if (cnt_error_overflow) begin
               state_d = HALT;
            end
`endif
         end
         CLR: state_d = RUN;
`ifdef COUNTER_ARB_HALT_ON_OVF_EN
         HALT: begin
            if (clr_req) begin
               state_d = CLR;
            end
         end
`endif
         default: state_d = RUN;
      endcase
   end

   // Outputs are gated by reset_L so they drop the instant reset asserts.
   always_comb begin
      req_ready = '0;
      cnt_en    = 1'b0;
      cnt_inc   = '0;
      cnt_clear = 1'b0;
      clr_ack   = 1'b0;
      ovf_halt  = 1'b0;
      if (reset_L) begin
         case (state_q)
            RUN: begin
               if (transfer) begin
                  req_ready = NUM_REQ'(1) << gnt_idx;
                  cnt_en    = 1'b1;
                  cnt_inc   = inc_arr[gnt_idx];
               end
            end
            CLR: begin
               cnt_clear = 1'b1;
               clr_ack   = 1'b1;
            end
`ifdef COUNTER_ARB_HALT_ON_OVF_EN
            HALT: ovf_halt = 1'b1;
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_arb.sv
// Scoreboard bench for counter_arb: a queue-rotation round-robin model predicts each
// cycle's outputs, and a separate monitor pops and compares them.
module tb_counter_arb;

   localparam int unsigned N  = 4;
   localparam int unsigned W  = 2;
   localparam int unsigned CS = 16;
   localparam int unsigned EW = N + 1 + W + 3;

   logic           clk;
   logic           reset_L;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_inc;
   logic [N-1:0]   req_ready;
   logic           clr_req;
   logic           clr_ack;
   logic           cnt_en;
   logic [W-1:0]   cnt_inc;
   logic           cnt_clear;
   logic           cnt_error_overflow;
   logic           ovf_halt;

   counter_arb #(.NUM_REQ(N), .CNT_INPUT_SIZE(W), .CNT_SIZE(CS)) dut (
      .clk                (clk),
      .reset_L            (reset_L),
      .req_valid          (req_valid),
      .req_inc            (req_inc),
      .req_ready          (req_ready),
      .clr_req            (clr_req),
      .clr_ack            (clr_ack),
      .cnt_en             (cnt_en),
      .cnt_inc            (cnt_inc),
      .cnt_clear          (cnt_clear),
      .cnt_error_overflow (cnt_error_overflow),
      .ovf_halt           (ovf_halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [EW-1:0] exp_q [$];
   int            checks = 0;
   int            errors = 0;

   // Model: priority order as a queue (front = highest), mode 0=run 1=clear 2=halt.
   int   order [$];
   int   mode;
   logic prev_ack;

   function automatic void model_reset();
      order.delete();
      for (int i = 0; i < N; i++) order.push_back(i);
      mode = 0;
   endfunction

   task automatic drive(input logic rst, input logic [N-1:0] v, input logic [N*W-1:0] inc,
                        input logic c, input logic o);
      logic [N-1:0] e_rdy;
      logic         e_en, e_clr, e_ack, e_halt;
      logic [W-1:0] e_inc;
      int           g, h;
      @(negedge clk);
      reset_L = rst; req_valid = v; req_inc = inc; clr_req = c; cnt_error_overflow = o;
      e_rdy = '0; e_en = 1'b0; e_inc = '0; e_clr = 1'b0; e_ack = 1'b0; e_halt = 1'b0;
      if (!rst) begin
         model_reset();
      end else if (mode == 1) begin
         e_clr = 1'b1; e_ack = 1'b1; mode = 0;
      end else if (mode == 2) begin
         e_halt = 1'b1;
         if (c) mode = 1;
      end else if (c) begin
         mode = 1;
      end else begin
         g = -1;
         foreach (order[j]) if (g < 0 && v[order[j]]) g = order[j];
         if (g >= 0) begin
            e_rdy[g] = 1'b1; e_en = 1'b1; e_inc = inc[g*W +: W];
            h = -1;
            while (h != g) begin
               h = order.pop_front();
               order.push_back(h);
            end
         end
`ifdef COUNTER_ARB_HALT_ON_OVF_EN
         if (o) mode = 2;
`endif
      end
      prev_ack = e_ack;
      exp_q.push_back({e_rdy, e_en, e_inc, e_clr, e_ack, e_halt});
   endtask

   task automatic drive_rand();
      logic         rst, c, o;
      logic [N-1:0] v;
      logic [N*W-1:0] inc;
      rst = ($urandom_range(0, 49) != 0);
      v   = N'($urandom);
      inc = (N*W)'($urandom);
      c   = prev_ack ? 1'b0 : ($urandom_range(0, 9) == 0);
      o   = ($urandom_range(0, 14) == 0);
      drive(rst, v, inc, c, o);
   endtask

   // Monitor: outputs are combinational, so every cycle presents a value to check.
   initial begin
      logic [EW-1:0] e, a;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {req_ready, cnt_en, cnt_inc, cnt_clear, clr_ack, ovf_halt};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL outputs t=%0t got rdy=%b en=%b inc=%0d clr=%b ack=%b halt=%b want rdy=%b en=%b inc=%0d clr=%b ack=%b halt=%b",
                        $time, a[EW-1 -: N], a[W+3], a[W+2 -: W], a[2], a[1], a[0],
                        e[EW-1 -: N], e[W+3], e[W+2 -: W], e[2], e[1], e[0]);
            end
         end
      end
   end

   initial begin
      reset_L = 1'b0; req_valid = '0; req_inc = '0; clr_req = 1'b0; cnt_error_overflow = 1'b0;
      prev_ack = 1'b0;
      model_reset();
      drive(0, 4'b1111, 8'hFF, 1'b0, 1'b0);
      drive(0, 4'b0000, 8'h00, 1'b0, 1'b0);
      // Full contention, unit increments: 0,1,2,3,0.
      for (int i = 0; i < 5; i++) drive(1, 4'b1111, 8'b01010101, 1'b0, 1'b0);
      // Lone requester 2, then 0 joins: alternation 0,2,0.
      drive(1, 4'b0100, 8'b00110000, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1, 4'b0101, 8'b00100011, 1'b0, 1'b0);
      // Zero increment still takes a turn.
      for (int i = 0; i < 3; i++) drive(1, 4'b1111, 8'h00, 1'b0, 1'b0);
      // Clear with full contention.
      drive(1, 4'b1111, 8'hE4, 1'b1, 1'b0);
      drive(1, 4'b1111, 8'hE4, 1'b1, 1'b0);
      drive(1, 4'b1111, 8'hE4, 1'b0, 1'b0);
      drive(1, 4'b1111, 8'hE4, 1'b0, 1'b0);
      // Overflow: halts only when the feature is built in.
      for (int i = 0; i < 3; i++) drive(1, 4'b1111, 8'h1B, 1'b0, 1'b1);
      drive(1, 4'b1111, 8'h1B, 1'b1, 1'b1);
      drive(1, 4'b1111, 8'h1B, 1'b1, 1'b0);
      drive(1, 4'b1111, 8'h1B, 1'b0, 1'b0);
      drive(1, 4'b1111, 8'h1B, 1'b0, 1'b0);
      // Reset in the middle of a clear.
      drive(1, 4'b1111, 8'h55, 1'b1, 1'b0);
      drive(0, 4'b1111, 8'h55, 1'b1, 1'b0);
      drive(1, 4'b1111, 8'h55, 1'b0, 1'b0);
      drive(1, 4'b1111, 8'h55, 1'b0, 1'b0);
      for (int i = 0; i < 400; i++) drive_rand();
      repeat (2) @(negedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
